// File: rtl/gate_response_checker.sv
// gate_response_checker
// Clocked checking end for the two-input logic-gate blocks. Walks {a,b}
// through 00,01,10,11 for NUM_PASSES sweeps. Each vector is held for
// SETTLE_CYCLES+1 cycles, and the five gate outputs are sampled on the last
// of those cycles. Mismatches are accumulated into a sticky per-gate mask, a
// saturating vector-error count and the first failing vector.
//
// Run handshake: start is a request that is accepted only in IDLE or DONE.
// busy is high for every APPLY cycle. done is a level that stays high in DONE
// until start, abort or rst. pass, err_count, fail_mask and first_fail are
// stable whenever done=1. abort wins over start in the same cycle.
//
// state_dbg encoding: IDLE=0, APPLY=1, DONE=2, which equals {done,busy}.
module gate_response_checker #(
   parameter int SETTLE_CYCLES = 2,
   parameter int NUM_PASSES    = 1,
   parameter int ERR_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             and_i,
   input  logic             or_i,
   input  logic             nor_i,
   input  logic             xor_i,
   input  logic             nand_i,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [4:0]       fail_mask,
   output logic [1:0]       first_fail,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [7:0]       SETTLE_L  = 8'(SETTLE_CYCLES);
   localparam logic [7:0]       LAST_PASS = 8'(NUM_PASSES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
   localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

   state_t           state_q, state_d;
   logic [1:0]       vec_q, vec_d;
   logic [7:0]       pidx_q, pidx_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             busy_d, done_d, pass_d;
   logic [ERR_W-1:0] err_d;
   logic [4:0]       mask_d;
   logic [1:0]       ff_d;

   logic [4:0]       expect_v;
   logic [4:0]       got_v;
   logic [4:0]       mism;

   // The stimulus pins are the vector register itself, so they are registered.
   assign a         = vec_q[1];
   assign b         = vec_q[0];
   assign state_dbg = state_q;

   // Reference truth table for the vector currently on a/b (bit order = fail_mask).
   assign expect_v = {~(vec_q[1] & vec_q[0]), vec_q[1] ^ vec_q[0],
                      ~(vec_q[1] | vec_q[0]), vec_q[1] | vec_q[0],
                      vec_q[1] & vec_q[0]};
   assign got_v    = {nand_i, xor_i, nor_i, or_i, and_i};
   assign mism     = got_v ^ expect_v;

   // Next-state and next-output logic; every register holds unless a case changes it.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      pidx_d  = pidx_q;
      cnt_d   = cnt_q;
      busy_d  = busy;
      done_d  = done;
      pass_d  = pass;
      err_d   = err_count;
      mask_d  = fail_mask;
      ff_d    = first_fail;

      case (state_q)
         IDLE, DONE: begin
            if (abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               vec_d   = 2'b00;
            end else if (start) begin
               state_d = APPLY;
               vec_d   = 2'b00;
               pidx_d  = 8'd0;
               cnt_d   = SETTLE_L;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               err_d   = '0;
               mask_d  = 5'b00000;
               ff_d    = 2'b00;
            end
         end

         APPLY: begin
            if (abort) begin
               // Any sample due this cycle is dropped; error state is kept for debug.
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               vec_d   = 2'b00;
            end else if (cnt_q == 8'd0) begin
               if (mism != 5'b00000) begin
                  mask_d = fail_mask | mism;
                  if (err_count != ERR_MAX) begin
                     err_d = err_count + ERR_ONE;
                  end
                  if (fail_mask == 5'b00000) begin
                     ff_d = vec_q;
                  end
               end
               cnt_d = SETTLE_L;
               if (vec_q == 2'b11) begin
                  if (pidx_q == LAST_PASS) begin
                     state_d = DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     pass_d  = (mask_d == 5'b00000);
                     vec_d   = 2'b00;
                  end else begin
                     pidx_d = pidx_q + 8'd1;
                     vec_d  = 2'b00;
                  end
               end else begin
                  vec_d = vec_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            vec_d   = 2'b00;
         end
      endcase
   end

   // State and output registers; rst clears everything, including mid-run.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         vec_q      <= 2'b00;
         pidx_q     <= 8'd0;
         cnt_q      <= 8'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_mask  <= 5'b00000;
         first_fail <= 2'b00;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         pidx_q     <= pidx_d;
         cnt_q      <= cnt_d;
         busy       <= busy_d;
         done       <= done_d;
         pass       <= pass_d;
         err_count  <= err_d;
         fail_mask  <= mask_d;
         first_fail <= ff_d;
      end
   end

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: two instances (slow settle / single pass,
// zero settle / three passes / narrow counter) driven by a faultable gate model.
module tb_gate_response_checker;

   localparam int S0 = 2;
   localparam int P0 = 1;
   localparam int E0 = 4;
   localparam int S1 = 0;
   localparam int P1 = 3;
   localparam int E1 = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  start_w;
   logic [1:0]  abort_w;
   int          mode_w [2];
   logic [19:0] tab_w  [2];
   logic        mon_en;

   int n_cmp;
   int n_fail;

   logic        a0, b0, busy0, done0, pass0;
   logic        a1, b1, busy1, done1, pass1;
   logic [3:0]  err0;
   logic [1:0]  err1;
   logic [4:0]  mask0, mask1;
   logic [1:0]  ff0, ff1, st0, st1;
   logic [4:0]  g0, g1;

   logic [1:0]  a_w, b_w, busy_w, done_w, pass_w;
   logic [3:0]  err_w  [2];
   logic [4:0]  mask_w [2];
   logic [1:0]  ff_w   [2];
   logic [1:0]  st_w   [2];

   logic [11:0] exp_q0[$];
   logic [11:0] exp_q1[$];

   // Gate truth table written out per input pair: {nand,xor,nor,or,and}.
   function automatic logic [4:0] truth(input logic x, input logic y);
      case ({x, y})
         2'b00:   return 5'b10100;
         2'b01:   return 5'b11010;
         2'b10:   return 5'b11010;
         default: return 5'b00011;
      endcase
   endfunction

   // Device-under-check behaviour: 0 good, 1 xor stuck-0, 2 nand/nor swapped,
   // 3 all inverted, 4 random per-vector inversion table.
   function automatic logic [4:0] dut_out(input int mode, input logic [19:0] tab,
                                          input logic x, input logic y);
      logic [4:0] t;
      t = truth(x, y);
      case (mode)
         1: t[3] = 1'b0;
         2: t = {t[2], t[3], t[4], t[1], t[0]};
         3: t = ~t;
         4: t = t ^ tab[int'({x, y}) * 5 +: 5];
         default: ;
      endcase
      return t;
   endfunction

   // Reference result after nsamp samples: {pass, err[3:0], mask, first_fail}.
   function automatic logic [11:0] model(input int mode, input logic [19:0] tab,
                                         input int nsamp, input int ew);
      int         errs;
      int         cap;
      logic [4:0] msk;
      logic [4:0] m;
      logic [1:0] ff;
      logic [1:0] vv;
      errs = 0;
      msk  = 5'b0;
      ff   = 2'b0;
      for (int j = 0; j < nsamp; j++) begin
         vv = 2'(j % 4);
         m  = dut_out(mode, tab, vv[1], vv[0]) ^ truth(vv[1], vv[0]);
         if (m != 5'b0) begin
            if (msk == 5'b0) ff = vv;
            msk  = msk | m;
            errs = errs + 1;
         end
      end
      cap = (1 << ew) - 1;
      if (errs > cap) errs = cap;
      return {(msk == 5'b0), 4'(errs), msk, ff};
   endfunction

   function automatic int s_of(input int i);
      return (i == 0) ? S0 : S1;
   endfunction
   function automatic int p_of(input int i);
      return (i == 0) ? P0 : P1;
   endfunction
   function automatic int e_of(input int i);
      return (i == 0) ? E0 : E1;
   endfunction

   // Faultable gate models feeding each checker.
   always_comb g0 = dut_out(mode_w[0], tab_w[0], a0, b0);
   always_comb g1 = dut_out(mode_w[1], tab_w[1], a1, b1);

   assign a_w    = {a1, a0};
   assign b_w    = {b1, b0};
   assign busy_w = {busy1, busy0};
   assign done_w = {done1, done0};
   assign pass_w = {pass1, pass0};
   always_comb begin
      err_w[0]  = err0;
      err_w[1]  = {2'b00, err1};
      mask_w[0] = mask0;
      mask_w[1] = mask1;
      ff_w[0]   = ff0;
      ff_w[1]   = ff1;
      st_w[0]   = st0;
      st_w[1]   = st1;
   end

   gate_response_checker #(.SETTLE_CYCLES(S0), .NUM_PASSES(P0), .ERR_W(E0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start_w[0]), .abort(abort_w[0]),
      .and_i(g0[0]), .or_i(g0[1]), .nor_i(g0[2]), .xor_i(g0[3]), .nand_i(g0[4]),
      .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .fail_mask(mask0), .first_fail(ff0), .state_dbg(st0)
   );

   gate_response_checker #(.SETTLE_CYCLES(S1), .NUM_PASSES(P1), .ERR_W(E1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start_w[1]), .abort(abort_w[1]),
      .and_i(g1[0]), .or_i(g1[1]), .nor_i(g1[2]), .xor_i(g1[3]), .nand_i(g1[4]),
      .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_mask(mask1), .first_fail(ff1), .state_dbg(st1)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   int   run_cyc  [2];
   int   last_run [2];
   logic prev_busy[2];
   logic prev_done[2];

   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 2; i++) begin
            logic [11:0] e;
            int          s;
            s = s_of(i);
            check("state_dbg", int'(st_w[i]), int'({done_w[i], busy_w[i]}));
            if (busy_w[i]) begin
               run_cyc[i]  = prev_busy[i] ? run_cyc[i] + 1 : 1;
               last_run[i] = run_cyc[i];
               check("ab_schedule", int'({a_w[i], b_w[i]}), ((run_cyc[i] - 1) / (s + 1)) % 4);
            end
            if (done_w[i] && !prev_done[i]) begin
               check("done_ab", int'({a_w[i], b_w[i]}), 0);
               check("run_length", last_run[i], 4 * (s + 1) * p_of(i));
               if (i == 0) check("queue_nonempty", exp_q0.size(), (exp_q0.size() > 0) ? exp_q0.size() : 1);
               else        check("queue_nonempty", exp_q1.size(), (exp_q1.size() > 0) ? exp_q1.size() : 1);
               e = 12'h0;
               if (i == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
               if (i == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
               check("pass", int'(pass_w[i]), int'(e[11]));
               check("err_count", int'(err_w[i]), int'(e[10:7]));
               check("fail_mask", int'(mask_w[i]), int'(e[6:2]));
               check("first_fail", int'(ff_w[i]), int'(e[1:0]));
            end
            prev_busy[i] = busy_w[i];
            prev_done[i] = done_w[i];
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push(input int i, input logic [11:0] e);
      if (i == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   task automatic setup(input int i, input int mode);
      mode_w[i] = mode;
      tab_w[i]  = 20'($urandom);
   endtask

   task automatic pulse_start(input int i);
      @(posedge clk); #1 start_w[i] = 1'b1;
      @(posedge clk); #1 start_w[i] = 1'b0;
   endtask

   task automatic wait_done(input int i);
      int k;
      k = 0;
      while (!done_w[i] && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      check("done_within_budget", int'(done_w[i]), 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic run(input int i, input int mode);
      setup(i, mode);
      push(i, model(mode, tab_w[i], 4 * p_of(i), e_of(i)));
      pulse_start(i);
      wait_done(i);
   endtask

   task automatic run_midstart(input int i, input int mode, input int k);
      setup(i, mode);
      push(i, model(mode, tab_w[i], 4 * p_of(i), e_of(i)));
      pulse_start(i);
      if (k > 1) repeat (k - 1) @(posedge clk);
      #1 start_w[i] = 1'b1;
      @(posedge clk); #1 start_w[i] = 1'b0;
      wait_done(i);
   endtask

   task automatic check_idle_kept(input int i, input logic [11:0] e);
      check("abort_busy", int'(busy_w[i]), 0);
      check("abort_done", int'(done_w[i]), 0);
      check("abort_ab", int'({a_w[i], b_w[i]}), 0);
      check("abort_err", int'(err_w[i]), int'(e[10:7]));
      check("abort_mask", int'(mask_w[i]), int'(e[6:2]));
      check("abort_ff", int'(ff_w[i]), int'(e[1:0]));
   endtask

   // abort sampled on the k-th APPLY edge after start; samples before it are kept.
   task automatic abort_at(input int i, input int mode, input int k, input logic with_start);
      logic [11:0] e;
      setup(i, mode);
      e = model(mode, tab_w[i], (k - 1) / (s_of(i) + 1), e_of(i));
      pulse_start(i);
      if (k > 1) repeat (k - 1) @(posedge clk);
      #1;
      abort_w[i] = 1'b1;
      start_w[i] = with_start;
      @(posedge clk); #1;
      abort_w[i] = 1'b0;
      start_w[i] = 1'b0;
      check_idle_kept(i, e);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic abort_start_in_done(input int i, input int mode);
      run(i, mode);
      abort_w[i] = 1'b1;
      start_w[i] = 1'b1;
      @(posedge clk); #1;
      abort_w[i] = 1'b0;
      start_w[i] = 1'b0;
      check_idle_kept(i, model(mode, tab_w[i], 4 * p_of(i), e_of(i)));
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input int i);
      check("rst_a", int'(a_w[i]), 0);
      check("rst_b", int'(b_w[i]), 0);
      check("rst_busy", int'(busy_w[i]), 0);
      check("rst_done", int'(done_w[i]), 0);
      check("rst_pass", int'(pass_w[i]), 0);
      check("rst_err", int'(err_w[i]), 0);
      check("rst_mask", int'(mask_w[i]), 0);
      check("rst_ff", int'(ff_w[i]), 0);
   endtask

   task automatic reset_mid(input int i, input int mode, input int k);
      setup(i, mode);
      pulse_start(i);
      if (k > 1) repeat (k - 1) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check_zero(0);
      check_zero(1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ---------------- main stimulus ----------------
   initial begin
      n_cmp      = 0;
      n_fail     = 0;
      mon_en     = 1'b0;
      rst        = 1'b1;
      start_w    = 2'b00;
      abort_w    = 2'b00;
      mode_w[0]  = 0;
      mode_w[1]  = 0;
      tab_w[0]   = 20'h0;
      tab_w[1]   = 20'h0;
      for (int i = 0; i < 2; i++) begin
         run_cyc[i]   = 0;
         last_run[i]  = 0;
         prev_busy[i] = 1'b0;
         prev_done[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_zero(0);
      check_zero(1);
      mon_en = 1'b1;

      // Directed runs on the settle-2 single-pass checker.
      run(0, 0);
      run(0, 1);
      run(0, 2);
      run(0, 3);
      abort_at(0, 1, 6, 1'b0);  // abort coincides with the 01 sample: it is dropped
      abort_at(0, 1, 8, 1'b0);  // after the 01 sample: xor failure retained
      run(0, 1);                // restart clears the retained state
      abort_at(0, 1, 5, 1'b1);  // abort beats start in APPLY
      abort_start_in_done(0, 1);
      run_midstart(0, 2, 5);
      reset_mid(0, 1, 8);

      // Directed runs on the zero-settle three-pass 2-bit-counter checker.
      run(1, 0);
      run(1, 2);
      run(1, 3);
      run_midstart(1, 3, 4);
      abort_at(1, 3, 5, 1'b0);

      // Randomized mix of runs, aborts and ignored restarts.
      for (int n = 0; n < 24; n++) begin
         int i;
         int mode;
         int len;
         int op;
         i    = $urandom_range(0, 1);
         mode = $urandom_range(0, 4);
         len  = 4 * (s_of(i) + 1) * p_of(i);
         op   = $urandom_range(0, 2);
         if (op == 0)      run(i, mode);
         else if (op == 1) abort_at(i, mode, $urandom_range(1, len), 1'($urandom_range(0, 1)));
         else              run_midstart(i, mode, $urandom_range(1, len));
      end

      repeat (3) @(posedge clk);
      #1;
      check("queue0_drained", exp_q0.size(), 0);
      check("queue1_drained", exp_q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
